// File: rtl/interrupt_dispatch_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : interrupt_dispatch_fsm                               |
// | Description : Masks pending interrupts with per-line enables,      |
// |               grants the lowest-index candidate, presents it to    |
// |               the CPU and runs the ack / end-of-interrupt          |
// |               handshake, pulsing a one-hot clear on acceptance.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module interrupt_dispatch_fsm #(
  parameter int NUM_IRQ = 3,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_clear,
  output logic               in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] cand;
  logic               cand_any;
  logic [ID_W-1:0]    winner;
  logic               req_live;
  logic [NUM_IRQ-1:0] grant_onehot;

  assign cand         = irq_pending & irq_enable;
  assign cand_any     = |cand;
  assign req_live     = irq_pending[irq_id] & irq_enable[irq_id];
  assign grant_onehot = {{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id;

  // Fixed-priority pick: scanning downward lets the lowest set index win.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) winner = ID_W'(i);
    end
  end

  // Dispatch FSM; every output is registered here, clear pulse defaults low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_irq    <= 1'b0;
      irq_id     <= '0;
      irq_clear  <= '0;
      in_service <= 1'b0;
    end else begin
      irq_clear <= '0;
      case (state)
        IDLE: begin
          if (cand_any) begin
            irq_id  <= winner;
            cpu_irq <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Ack beats withdrawal; the granted ID is never re-arbitrated here.
          if (cpu_ack) begin
            irq_clear  <= grant_onehot;
            cpu_irq    <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end else if (!req_live) begin
            cpu_irq <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (cpu_eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          cpu_irq    <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
